// File: rtl/pong_pkg.sv
// Shared constants and types for the pong game front-end.
package pong_pkg;

    // Button channel indices
    localparam int BTN_B1_LEFT  = 0;
    localparam int BTN_B1_RIGHT = 1;
    localparam int BTN_B2_LEFT  = 2;
    localparam int BTN_B2_RIGHT = 3;
    localparam int BTN_SERVE    = 4;

    // Default timing at 50 MHz
    localparam int DEF_N_BTN           = 5;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;
    localparam int DEF_CNT_W           = 26;

    // Press/auto-repeat state per button
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } btn_state_e;

    // Map a pin level to "pressed" (1) given the board polarity
    function automatic logic to_pressed(input logic pin, input bit active_low);
        return active_low ? ~pin : pin;
    endfunction

endpackage

// File: rtl/button_debounce_repeat_if.sv
// Button bundle between the board pins / game core and the debouncer.
interface button_debounce_repeat_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_ack;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_evt;
    logic [N_BTN-1:0] btn_pend;

    // Driver of raw pins and acknowledges, consumer of events
    modport master (
        output btn_raw, btn_ack,
        input  btn_level, btn_evt, btn_pend
    );

    // The debouncer itself
    modport slave (
        input  btn_raw, btn_ack,
        output btn_level, btn_evt, btn_pend
    );
endinterface

// File: rtl/debounce_channel.sv
// One button: synchroniser, debounce counter, press/repeat FSM, sticky pending flag.
module debounce_channel
    import pong_pkg::*;
#(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic raw,
    input  logic ack,
    output logic level,
    output logic evt,
    output logic pend
);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic             RELEASED = ACTIVE_LOW;

    logic             sync_p0;
    logic             sync_p1;
    logic             s;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] hold_cnt;
    btn_state_e       state;
    logic             db_flip;
    logic             rise;
    logic             fall;

    // Two-flop synchroniser; reset to the released pin level so reset never looks like a press
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync_p0 <= RELEASED;
            sync_p1 <= RELEASED;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    assign s       = to_pressed(sync_p1, ACTIVE_LOW);
    // Level edges are known one cycle early so the FSM can register evt alongside the level edge
    assign db_flip = (s != level) && (db_cnt == DB_LAST);
    assign rise    = db_flip && s;
    assign fall    = db_flip && !s;

    // Debounce: level follows s only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (s == level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            level  <= s;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Press / auto-repeat FSM; release ends the hold with no event
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= IDLE;
            hold_cnt <= '0;
            evt      <= 1'b0;
        end else begin
            evt <= 1'b0;
            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (rise) begin
                        evt   <= 1'b1;
                        state <= DELAY;
                    end
                end
                DELAY: begin
                    if (fall) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end else if (hold_cnt == RD_LAST) begin
                        evt      <= 1'b1;
                        hold_cnt <= '0;
                        state    <= REPEAT;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (fall) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end else if (hold_cnt == RP_LAST) begin
                        evt      <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    // Sticky pending flag; a new event beats a coincident acknowledge
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pend <= 1'b0;
        end else begin
            pend <= evt | (pend & ~ack);
        end
    end

endmodule

// File: rtl/button_debounce_repeat.sv
// Push-button front-end for the pong core: N_BTN independent debounce/repeat channels.
module button_debounce_repeat
    import pong_pkg::*;
#(
    parameter int N_BTN           = DEF_N_BTN,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_W           = DEF_CNT_W
) (
    input logic                     CLK,
    input logic                     RSTn,
    button_debounce_repeat_if.slave bus
);
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] evt;
    logic [N_BTN-1:0] pend;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .CNT_W           (CNT_W)
        ) u_ch (
            .CLK   (CLK),
            .RSTn  (RSTn),
            .raw   (bus.btn_raw[i]),
            .ack   (bus.btn_ack[i]),
            .level (level[i]),
            .evt   (evt[i]),
            .pend  (pend[i])
        );
    end

    assign bus.btn_level = level;
    assign bus.btn_evt   = evt;
    assign bus.btn_pend  = pend;

endmodule

// File: tb/tb_button_debounce_repeat.sv
// Bench for button_debounce_repeat: directed scenarios plus random stimulus against a reference model.
module tb_button_debounce_repeat;
    import pong_pkg::*;

    localparam int NB = 5;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic          CLK  = 1'b0;
    logic          RSTn = 1'b0;
    logic [NB-1:0] raw  = '1;
    logic [NB-1:0] ack  = '0;

    int errs   = 0;
    int checks = 0;

    button_debounce_repeat_if #(.N_BTN(NB)) bus ();

    assign bus.btn_raw = raw;
    assign bus.btn_ack = ack;

    button_debounce_repeat #(
        .N_BTN           (NB),
        .ACTIVE_LOW      (1'b1),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .CNT_W           (8)
    ) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pressed samples reach the debouncer two clocks late; the stable
    // level flips once the last D samples all disagree with it; events fire at the press
    // and then at hold times RD, RD+RP, RD+2RP, ... measured from the press.
    logic [NB-1:0] m_pipe0 = '0;
    logic [NB-1:0] m_pipe1 = '0;
    logic [D-1:0]  m_hist [NB];
    logic [NB-1:0] m_level = '0;
    logic [NB-1:0] m_evt   = '0;
    logic [NB-1:0] m_pend  = '0;
    int            m_press [NB];
    int            cyc = 0;

    task automatic model_reset();
        m_pipe0 = '0;
        m_pipe1 = '0;
        m_level = '0;
        m_evt   = '0;
        m_pend  = '0;
        cyc     = 0;
        for (int i = 0; i < NB; i++) begin
            m_hist[i]  = '0;
            m_press[i] = 0;
        end
    endtask

    task automatic model_step();
        logic s;
        logic flip;
        int   held;
        cyc++;
        for (int i = 0; i < NB; i++) begin
            s          = m_pipe1[i];
            m_pipe1[i] = m_pipe0[i];
            m_pipe0[i] = ~raw[i];
            m_hist[i]  = {m_hist[i][D-2:0], s};
            flip       = (m_hist[i] == (m_level[i] ? {D{1'b0}} : {D{1'b1}}));
            m_pend[i]  = m_evt[i] | (m_pend[i] & ~ack[i]);
            m_evt[i]   = 1'b0;
            if (flip) begin
                m_level[i] = ~m_level[i];
                if (m_level[i]) begin
                    m_press[i] = cyc;
                    m_evt[i]   = 1'b1;
                end
            end else if (m_level[i]) begin
                held = cyc - m_press[i];
                if (held >= RD && ((held - RD) % RP) == 0) m_evt[i] = 1'b1;
            end
        end
    endtask

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) model_reset();
        else       model_step();
    end

    always @(negedge CLK) begin
        check("level", 32'(bus.btn_level), 32'(m_level));
        check("evt",   32'(bus.btn_evt),   32'(m_evt));
        check("pend",  32'(bus.btn_pend),  32'(m_pend));
    end

    task automatic check_async_reset(input string tag);
        #2 RSTn = 1'b0;
        #1;
        check({tag, "_level"}, 32'(bus.btn_level), 32'd0);
        check({tag, "_evt"},   32'(bus.btn_evt),   32'd0);
        check({tag, "_pend"},  32'(bus.btn_pend),  32'd0);
    endtask

    initial begin
        int cnt;
        bit found;
        model_reset();
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);

        // Clean press on bar1-left, timing from raw edge
        raw[BTN_B1_LEFT] = 1'b0;
        repeat (5) @(negedge CLK);
        check("t1_level_early", 32'(bus.btn_level[BTN_B1_LEFT]), 32'd0);
        @(negedge CLK);
        check("t1_evt", 32'(bus.btn_evt[BTN_B1_LEFT]), 32'd1);
        check("t1_level", 32'(bus.btn_level[BTN_B1_LEFT]), 32'd1);
        check("t1_pend_early", 32'(bus.btn_pend[BTN_B1_LEFT]), 32'd0);
        @(negedge CLK);
        check("t1_pend", 32'(bus.btn_pend[BTN_B1_LEFT]), 32'd1);
        check("t1_evt_single", 32'(bus.btn_evt[BTN_B1_LEFT]), 32'd0);

        // Handshake: plain ack, then ack coincident with a repeat event
        ack[BTN_B1_LEFT] = 1'b1;
        @(negedge CLK);
        ack[BTN_B1_LEFT] = 1'b0;
        check("t4_ack_clears", 32'(bus.btn_pend[BTN_B1_LEFT]), 32'd0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge CLK);
            if (m_evt[BTN_B1_LEFT]) found = 1'b1;
        end
        check("t4_repeat_seen", 32'(found), 32'd1);
        ack[BTN_B1_LEFT] = 1'b1;
        @(negedge CLK);
        ack[BTN_B1_LEFT] = 1'b0;
        check("t4_evt_beats_ack", 32'(bus.btn_pend[BTN_B1_LEFT]), 32'd1);
        raw[BTN_B1_LEFT] = 1'b1;
        repeat (10) @(negedge CLK);

        // Glitch shorter than the debounce window
        raw[BTN_B1_RIGHT] = 1'b0;
        repeat (3) @(negedge CLK);
        raw[BTN_B1_RIGHT] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            check("t2_quiet", 32'({bus.btn_level[BTN_B1_RIGHT], bus.btn_evt[BTN_B1_RIGHT],
                                   bus.btn_pend[BTN_B1_RIGHT]}), 32'd0);
        end

        // Auto-repeat on bar2-left held for 40 cycles
        raw[BTN_B2_LEFT] = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (bus.btn_evt[BTN_B2_LEFT]) cnt++;
            if (k == 16) check("t3_first_repeat", 32'(bus.btn_evt[BTN_B2_LEFT]), 32'd1);
        end
        check("t3_pulses", 32'(cnt), 32'd6);
        raw[BTN_B2_LEFT] = 1'b1;
        repeat (5) @(negedge CLK);
        check("t3_level_hold", 32'(bus.btn_level[BTN_B2_LEFT]), 32'd1);
        @(negedge CLK);
        check("t3_level_released", 32'(bus.btn_level[BTN_B2_LEFT]), 32'd0);
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge CLK);
            if (bus.btn_evt[BTN_B2_LEFT]) cnt++;
        end
        check("t3_no_evt_after_release", 32'(cnt), 32'd0);

        // Reset in the middle of a hold on bar2-right
        raw[BTN_B2_RIGHT] = 1'b0;
        repeat (12) @(negedge CLK);
        check_async_reset("t5_reset");
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        repeat (5) @(negedge CLK);
        check("t5_no_early_evt", 32'(bus.btn_evt[BTN_B2_RIGHT]), 32'd0);
        @(negedge CLK);
        check("t5_fresh_evt", 32'(bus.btn_evt[BTN_B2_RIGHT]), 32'd1);
        raw[BTN_B2_RIGHT] = 1'b1;
        repeat (12) @(negedge CLK);
        ack = '1;
        @(negedge CLK);
        ack = '0;

        // All buttons together, then ack serve only
        raw = '0;
        repeat (6) @(negedge CLK);
        check("t6_evt_all", 32'(bus.btn_evt), 32'h1F);
        @(negedge CLK);
        check("t6_pend_all", 32'(bus.btn_pend), 32'h1F);
        ack[BTN_SERVE] = 1'b1;
        @(negedge CLK);
        ack = '0;
        check("t6_pend_ack_serve", 32'(bus.btn_pend), 32'h0F);
        raw = '1;
        repeat (12) @(negedge CLK);

        // Random press patterns and acknowledges, with one reset in the middle
        for (int c = 0; c < 2500; c++) begin
            @(negedge CLK);
            if (c == 1300) RSTn = 1'b1;
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 19) == 0) raw[i] = ~raw[i];
            ack = NB'($urandom) & NB'($urandom);
            if (c == 1297) check_async_reset("rnd_reset");
        end

        raw = '1;
        ack = '0;
        repeat (3) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
